signal_head_monitor: RTL

Receiving end of the controller's light stream. Samples `{road, light_out}` whenever `light_valid` is high and drives per-road lamp registers. Checks every update for an illegal code, a cross-road conflict, an illegal sequence, and stream loss. On any violation it drops to a latched fail-safe that flashes red on all roads. It sits between the controller top and the physical signal heads.

---
 rtl/signal_head_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/signal_head_monitor.sv
// rtl/signal_head_monitor.sv - lamp-stream checker with latched flashing-red fail-safe
module signal_head_monitor #(
   parameter int  roads        = 4,
   parameter int  timeout      = 255,
   parameter int  blink_period = 8,
   localparam int roads_size   = (roads > 1) ? $clog2(roads) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            light_out,
   input  logic [roads_size-1:0] road,
   input  logic                  light_valid,
   input  logic                  clear_fault,
   output logic [3*roads-1:0]    lamps,
   output logic                  fault,
   output logic [2:0]            fault_code,
   output logic [roads_size-1:0] active_road,
   output logic                  any_go
);
   localparam int wd_w = (timeout > 0) ? $clog2(timeout + 1) : 1;
   localparam int bl_w = (blink_period > 1) ? $clog2(blink_period) : 1;
   localparam logic [wd_w-1:0] wd_limit = wd_w'(timeout);
   localparam logic [bl_w-1:0] bl_last  = bl_w'(blink_period - 1);

   localparam logic [2:0] red    = 3'b100;
   localparam logic [2:0] yellow = 3'b010;
   localparam logic [2:0] green  = 3'b001;

   localparam logic [2:0] fc_none     = 3'd0;
   localparam logic [2:0] fc_code     = 3'd1;
   localparam logic [2:0] fc_seq      = 3'd2;
   localparam logic [2:0] fc_conflict = 3'd3;
   localparam logic [2:0] fc_timeout  = 3'd4;

   localparam logic [3*roads-1:0] all_red = {roads{red}};

   typedef enum logic [1:0] {s_init, s_run, s_fault} state_t;

   state_t                state;
   logic [2:0]            stored [roads];
   logic [wd_w-1:0]       wd_cnt;
   logic [bl_w-1:0]       blink_cnt;
   logic                  blink_on;

   logic                  code_err;
   logic                  conflict_err;
   logic                  seq_err;
   logic [2:0]            cur;
   logic [2:0]            hit_code;
   logic [2:0]            st_app [roads];
   logic [3*roads-1:0]    app_lamps;
   logic [roads_size-1:0] app_active;
   logic                  app_go;

   always_comb begin
      code_err = !(light_out inside {red, yellow, green}) || (int'(road) >= roads);

      cur = red;
      if (!code_err) cur = stored[road];

      conflict_err = 1'b0;
      for (int r = 0; r < roads; r++) begin
         if (r != int'(road) && stored[r] != red && light_out != red) conflict_err = 1'b1;
      end

      seq_err = !((light_out == cur) ||
                  (cur == red    && light_out == green)  ||
                  (cur == green  && light_out == yellow) ||
                  (cur == yellow && light_out == red));

      // Stored image as it would look if this sample were accepted
      st_app = stored;
      if (!code_err) st_app[road] = light_out;

      app_lamps  = '0;
      app_active = '0;
      app_go     = 1'b0;
      for (int r = 0; r < roads; r++) begin
         app_lamps[3*r +: 3] = st_app[r];
         if (st_app[r] != red) begin
            app_active = roads_size'(r);
            app_go     = 1'b1;
         end
      end

      hit_code = fc_none;
      if (state != s_fault) begin
         if (light_valid) begin
            if (code_err)          hit_code = fc_code;
            else if (conflict_err) hit_code = fc_conflict;
            else if (seq_err)      hit_code = fc_seq;
         end else if (state == s_run && wd_cnt == wd_limit) begin
            hit_code = fc_timeout;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= s_init;
         for (int r = 0; r < roads; r++) stored[r] <= red;
         lamps       <= all_red;
         fault       <= 1'b0;
         fault_code  <= fc_none;
         active_road <= '0;
         any_go      <= 1'b0;
         wd_cnt      <= '0;
         blink_cnt   <= '0;
         blink_on    <= 1'b0;
      end else begin
         case (state)
            s_init, s_run: begin
               if (hit_code != fc_none) begin
                  state       <= s_fault;
                  fault       <= 1'b1;
                  fault_code  <= hit_code;
                  lamps       <= all_red;
                  blink_cnt   <= '0;
                  blink_on    <= 1'b1;
                  active_road <= '0;
                  any_go      <= 1'b0;
               end else if (light_valid) begin
                  state       <= s_run;
                  stored      <= st_app;
                  lamps       <= app_lamps;
                  active_road <= app_active;
                  any_go      <= app_go;
                  wd_cnt      <= '0;
               end else if (state == s_run && wd_cnt != wd_limit) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            s_fault: begin
               if (clear_fault) begin
                  state <= s_init;
                  for (int r = 0; r < roads; r++) stored[r] <= red;
                  lamps       <= all_red;
                  fault       <= 1'b0;
                  fault_code  <= fc_none;
                  active_road <= '0;
                  any_go      <= 1'b0;
                  wd_cnt      <= '0;
                  blink_cnt   <= '0;
                  blink_on    <= 1'b0;
               end else if (blink_cnt == bl_last) begin
                  blink_cnt <= '0;
                  blink_on  <= !blink_on;
                  lamps     <= blink_on ? '0 : all_red;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
            default: state <= s_init;
         endcase
      end
   end
endmodule
